// File: rtl/mouse_pos_tracker.sv
// Two-stage PS/2 mouse tracker: stage 1 transforms the packet deltas, stage 2 updates
// the clamped screen position and button state and queues button-change events.
module mouse_pos_tracker #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int X_POS_W    = 10,
  parameter int Y_POS_W    = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         pkt_valid_i,
  input  logic [8:0]                   pkt_dx_i,
  input  logic [8:0]                   pkt_dy_i,
  input  logic [2:0]                   pkt_btn_i,
  input  logic                         cfg_swap_i,
  input  logic                         cfg_inv_x_i,
  input  logic                         cfg_inv_y_i,
  input  logic [1:0]                   cfg_shift_i,
  input  logic                         pos_load_i,
  input  logic [X_POS_W-1:0]           pos_x_i,
  input  logic [Y_POS_W-1:0]           pos_y_i,
  input  logic [2:0]                   ack_i,
  output logic [X_POS_W-1:0]           x_pos_o,
  output logic [Y_POS_W-1:0]           y_pos_o,
  output logic [2:0]                   btn_state_o,
  output logic [2:0]                   btn_sticky_o,
  output logic                         evt_valid_o,
  input  logic                         evt_ready_i,
  output logic [X_POS_W+Y_POS_W+2:0]   evt_data_o,
  output logic                         evt_ovf_o,
  input  logic                         clr_ovf_i
);

  localparam int EVT_W = X_POS_W + Y_POS_W + 3;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int POS_W = (X_POS_W > Y_POS_W) ? X_POS_W : Y_POS_W;
  // Headroom so position +/- the largest shifted delta can never wrap.
  localparam int SUM_W = ((POS_W > 13) ? POS_W : 13) + 2;

  function automatic logic [X_POS_W-1:0] sat_x(input logic signed [SUM_W-1:0] v);
    if (v < 0)                          sat_x = '0;
    else if (v > SUM_W'(WIDTH - 1))     sat_x = X_POS_W'(WIDTH - 1);
    else                                sat_x = v[X_POS_W-1:0];
  endfunction

  function automatic logic [Y_POS_W-1:0] sat_y(input logic signed [SUM_W-1:0] v);
    if (v < 0)                          sat_y = '0;
    else if (v > SUM_W'(HEIGHT - 1))    sat_y = Y_POS_W'(HEIGHT - 1);
    else                                sat_y = v[Y_POS_W-1:0];
  endfunction

  logic signed [12:0] dx_ext, dy_ext, dx_sw, dy_sw, dx_tr, dy_tr;
  logic signed [12:0] dx_p1, dy_p1;
  logic [2:0]         btn_p1;
  logic               vld_p1;

  always_comb begin
    dx_ext = {{4{pkt_dx_i[8]}}, pkt_dx_i};
    dy_ext = {{4{pkt_dy_i[8]}}, pkt_dy_i};
    dx_sw  = cfg_swap_i ? dy_ext : dx_ext;
    dy_sw  = cfg_swap_i ? dx_ext : dy_ext;
    dx_tr  = (cfg_inv_x_i ? -dx_sw : dx_sw) <<< cfg_shift_i;
    dy_tr  = (cfg_inv_y_i ? -dy_sw : dy_sw) <<< cfg_shift_i;
  end

  // Stage 1: capture transformed deltas and buttons
  always_ff @(posedge clk_i) begin
    if (pkt_valid_i) begin
      dx_p1  <= dx_tr;
      dy_p1  <= dy_tr;
      btn_p1 <= pkt_btn_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) vld_p1 <= 1'b0;
    else         vld_p1 <= pkt_valid_i;
  end

  logic [X_POS_W-1:0]        x_pos_p2, x_new;
  logic [Y_POS_W-1:0]        y_pos_p2, y_new;
  logic [2:0]                btn_state_p2, btn_sticky_p2, sticky_nxt;
  logic signed [SUM_W-1:0]   x_sum, y_sum;
  logic                      push;

  always_comb begin
    x_sum      = SUM_W'(signed'({1'b0, x_pos_p2})) + SUM_W'(dx_p1);
    y_sum      = SUM_W'(signed'({1'b0, y_pos_p2})) - SUM_W'(dy_p1);
    x_new      = pos_load_i ? sat_x(SUM_W'(signed'({1'b0, pos_x_i}))) : sat_x(x_sum);
    y_new      = pos_load_i ? sat_y(SUM_W'(signed'({1'b0, pos_y_i}))) : sat_y(y_sum);
    push       = vld_p1 && (btn_p1 != btn_state_p2);
    sticky_nxt = (btn_sticky_p2 & ~ack_i) | (vld_p1 ? btn_p1 : 3'b000);
  end

  // Stage 2: position, button state, sticky buttons
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      x_pos_p2      <= X_POS_W'(WIDTH / 2);
      y_pos_p2      <= Y_POS_W'(HEIGHT / 2);
      btn_state_p2  <= '0;
      btn_sticky_p2 <= '0;
    end else begin
      if (pos_load_i || vld_p1) begin
        x_pos_p2 <= x_new;
        y_pos_p2 <= y_new;
      end
      if (vld_p1) btn_state_p2 <= btn_p1;
      btn_sticky_p2 <= sticky_nxt;
    end
  end

  logic [EVT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, pop, wr_en, ovf_set, ovf_q;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop     = !empty && evt_ready_i;
    wr_en   = push && (!full || pop);
    ovf_set = push && full && !pop;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) fifo_mem[wr_ptr[AW-1:0]] <= {x_new, y_new, btn_p1};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      ovf_q <= ovf_set | (ovf_q & ~clr_ovf_i);
    end
  end

  assign x_pos_o      = x_pos_p2;
  assign y_pos_o      = y_pos_p2;
  assign btn_state_o  = btn_state_p2;
  assign btn_sticky_o = btn_sticky_p2;
  assign evt_valid_o  = !empty;
  assign evt_data_o   = fifo_mem[rd_ptr[AW-1:0]];
  assign evt_ovf_o    = ovf_q;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Scoreboard bench for mouse_pos_tracker: a behavioural model queues expected
// positions and FIFO events as packets are driven; the DUT is compared on negedges.
module tb_mouse_pos_tracker;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        pkt_valid_i;
  logic [8:0]  pkt_dx_i, pkt_dy_i;
  logic [2:0]  pkt_btn_i;
  logic        cfg_swap_i, cfg_inv_x_i, cfg_inv_y_i;
  logic [1:0]  cfg_shift_i;
  logic        pos_load_i;
  logic [9:0]  pos_x_i;
  logic [8:0]  pos_y_i;
  logic [2:0]  ack_i;
  logic [9:0]  x_pos_o;
  logic [8:0]  y_pos_o;
  logic [2:0]  btn_state_o, btn_sticky_o;
  logic        evt_valid_o, evt_ready_i;
  logic [21:0] evt_data_o;
  logic        evt_ovf_o, clr_ovf_i;

  always #5 clk_i = ~clk_i;

  mouse_pos_tracker dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .pkt_valid_i(pkt_valid_i), .pkt_dx_i(pkt_dx_i), .pkt_dy_i(pkt_dy_i), .pkt_btn_i(pkt_btn_i),
    .cfg_swap_i(cfg_swap_i), .cfg_inv_x_i(cfg_inv_x_i), .cfg_inv_y_i(cfg_inv_y_i),
    .cfg_shift_i(cfg_shift_i),
    .pos_load_i(pos_load_i), .pos_x_i(pos_x_i), .pos_y_i(pos_y_i), .ack_i(ack_i),
    .x_pos_o(x_pos_o), .y_pos_o(y_pos_o), .btn_state_o(btn_state_o), .btn_sticky_o(btn_sticky_o),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_data_o(evt_data_o),
    .evt_ovf_o(evt_ovf_o), .clr_ovf_i(clr_ovf_i)
  );

  int          checks = 0;
  int          errors = 0;
  logic [21:0] pos_q[$];
  logic [21:0] evt_q[$];
  int          mx, my;
  logic [2:0]  mbtn;
  bit          exp_ovf;

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    mx = 320; my = 240; mbtn = 3'b000; exp_ovf = 1'b0;
    pos_q.delete(); evt_q.delete();
  endtask

  // Drives one packet (valid stays high until the caller lowers it) and updates the model.
  task automatic drive_pkt(input logic [8:0] dx, input logic [8:0] dy, input logic [2:0] btn,
                           input bit ld, input int lx, input int ly);
    int a, b, t;
    pkt_dx_i = dx; pkt_dy_i = dy; pkt_btn_i = btn; pkt_valid_i = 1'b1;
    a = int'($signed(dx));
    b = int'($signed(dy));
    if (cfg_swap_i) begin t = a; a = b; b = t; end
    if (cfg_inv_x_i) a = -a;
    if (cfg_inv_y_i) b = -b;
    a = a * (1 << cfg_shift_i);
    b = b * (1 << cfg_shift_i);
    if (ld) begin mx = clamp(lx, 639); my = clamp(ly, 479); end
    else begin mx = clamp(mx + a, 639); my = clamp(my - b, 479); end
    if (btn != mbtn) begin
      if (evt_q.size() < 4) evt_q.push_back({10'(mx), 9'(my), btn});
      else exp_ovf = 1'b1;
    end
    mbtn = btn;
    pos_q.push_back({10'(mx), 9'(my), btn});
  endtask

  task automatic test_reset();
    logic [21:0] e;
    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (x_pos_o !== 10'd320 || y_pos_o !== 9'd240) begin
      errors++; $display("FAIL reset_pos: got (%0d,%0d) want (320,240)", x_pos_o, y_pos_o);
    end
    rstn_i = 1'b1;
    model_reset();
    @(negedge clk_i);
    e = {10'd320, 9'd240, 3'b000};
    checks++;
    if ({x_pos_o, y_pos_o, btn_sticky_o} !== e || evt_valid_o !== 1'b0 || evt_ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got x=%0d y=%0d sticky=%b vld=%b ovf=%b want x=320 y=240 sticky=000 vld=0 ovf=0",
               x_pos_o, y_pos_o, btn_sticky_o, evt_valid_o, evt_ovf_o);
    end
  endtask

  task automatic test_move();
    logic [21:0] e;
    drive_pkt(9'h005, 9'h1FD, 3'b000, 0, 0, 0);
    @(negedge clk_i);
    pkt_valid_i = 1'b0;
    checks++;
    if (x_pos_o !== 10'd320 || y_pos_o !== 9'd240) begin
      errors++; $display("FAIL move_early: got (%0d,%0d) want (320,240)", x_pos_o, y_pos_o);
    end
    @(negedge clk_i);
    e = pos_q.pop_front();
    checks++;
    if (x_pos_o !== e[21:12] || y_pos_o !== e[11:3] || x_pos_o !== 10'd325 || y_pos_o !== 9'd243) begin
      errors++; $display("FAIL move_pos: got (%0d,%0d) want (%0d,%0d)", x_pos_o, y_pos_o, e[21:12], e[11:3]);
    end
    checks++;
    if (evt_valid_o !== 1'b0) begin
      errors++; $display("FAIL move_nopush: got evt_valid=%b want 0", evt_valid_o);
    end
  endtask

  task automatic test_clamp();
    logic [21:0] e;
    logic [8:0]  dxs[7] = '{9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h000, 9'h000};
    logic [8:0]  dys[7] = '{9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h0FF, 9'h004};
    logic [1:0]  shs[7] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    bit          ivx[7] = '{0, 0, 1, 1, 1, 0, 0};
    bit          swp[7] = '{0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      cfg_shift_i = shs[i]; cfg_inv_x_i = ivx[i]; cfg_swap_i = swp[i];
      drive_pkt(dxs[i], dys[i], 3'b000, 0, 0, 0);
      @(negedge clk_i);
      pkt_valid_i = 1'b0;
      // scramble config while the packet is in stage 2
      cfg_shift_i = 2'd3; cfg_inv_x_i = 1'b1; cfg_inv_y_i = 1'b1; cfg_swap_i = ~cfg_swap_i;
      @(negedge clk_i);
      cfg_inv_y_i = 1'b0;
      e = pos_q.pop_front();
      checks++;
      if (x_pos_o !== e[21:12] || y_pos_o !== e[11:3]) begin
        errors++; $display("FAIL clamp_%0d: got (%0d,%0d) want (%0d,%0d)", i, x_pos_o, y_pos_o, e[21:12], e[11:3]);
      end
    end
    cfg_shift_i = 2'd0; cfg_inv_x_i = 1'b0; cfg_swap_i = 1'b0;
  endtask

  task automatic test_fifo_ovf();
    logic [21:0] e;
    for (int i = 0; i < 7; i++) begin
      if (i >= 2) begin
        e = pos_q.pop_front();
        checks++;
        if (x_pos_o !== e[21:12] || y_pos_o !== e[11:3] || btn_state_o !== e[2:0]) begin
          errors++; $display("FAIL fifo_pos_%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)", i,
                             x_pos_o, y_pos_o, btn_state_o, e[21:12], e[11:3], e[2:0]);
        end
      end
      if (i < 5) drive_pkt(9'h000, 9'h000, (i % 2 == 0) ? 3'b001 : 3'b000, 0, 0, 0);
      else pkt_valid_i = 1'b0;
      @(negedge clk_i);
    end
    checks++;
    if (evt_ovf_o !== exp_ovf || exp_ovf !== 1'b1) begin
      errors++; $display("FAIL fifo_ovf: got %b want 1", evt_ovf_o);
    end
    evt_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = evt_q.pop_front();
      checks++;
      if (evt_valid_o !== 1'b1 || evt_data_o !== e || evt_data_o[2:0] !== ((i % 2 == 0) ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL fifo_pop_%0d: got vld=%b data=%h want vld=1 data=%h", i, evt_valid_o, evt_data_o, e);
      end
      @(negedge clk_i);
    end
    @(negedge clk_i);
    evt_ready_i = 1'b0;
    checks++;
    if (evt_valid_o !== 1'b0) begin
      errors++; $display("FAIL fifo_empty: got evt_valid=%b want 0", evt_valid_o);
    end
    clr_ovf_i = 1'b1;
    @(negedge clk_i);
    clr_ovf_i = 1'b0; exp_ovf = 1'b0;
    checks++;
    if (evt_ovf_o !== 1'b0) begin
      errors++; $display("FAIL fifo_clr_ovf: got %b want 0", evt_ovf_o);
    end
  endtask

  task automatic test_sticky();
    logic [21:0] e;
    checks++;
    if (btn_sticky_o !== 3'b001) begin
      errors++; $display("FAIL sticky_init: got %b want 001", btn_sticky_o);
    end
    ack_i = 3'b111;
    @(negedge clk_i);
    ack_i = 3'b000;
    checks++;
    if (btn_sticky_o !== 3'b000) begin
      errors++; $display("FAIL sticky_ack_all: got %b want 000", btn_sticky_o);
    end
    drive_pkt(9'h000, 9'h000, 3'b010, 0, 0, 0);
    @(negedge clk_i);
    pkt_valid_i = 1'b0;
    @(negedge clk_i);
    e = pos_q.pop_front();
    checks++;
    if (btn_sticky_o !== 3'b010 || btn_state_o !== e[2:0]) begin
      errors++; $display("FAIL sticky_set: got sticky=%b state=%b want sticky=010 state=%b", btn_sticky_o, btn_state_o, e[2:0]);
    end
    drive_pkt(9'h000, 9'h000, 3'b010, 0, 0, 0);
    @(negedge clk_i);
    pkt_valid_i = 1'b0; ack_i = 3'b010;
    @(negedge clk_i);
    ack_i = 3'b000;
    void'(pos_q.pop_front());
    checks++;
    if (btn_sticky_o !== 3'b010) begin
      errors++; $display("FAIL sticky_set_wins: got %b want 010", btn_sticky_o);
    end
    ack_i = 3'b010;
    @(negedge clk_i);
    ack_i = 3'b000;
    checks++;
    if (btn_sticky_o !== 3'b000) begin
      errors++; $display("FAIL sticky_ack: got %b want 000", btn_sticky_o);
    end
    while (evt_q.size() > 0) begin
      e = evt_q.pop_front();
      checks++;
      if (evt_valid_o !== 1'b1 || evt_data_o !== e) begin
        errors++; $display("FAIL sticky_evt: got vld=%b data=%h want vld=1 data=%h", evt_valid_o, evt_data_o, e);
      end
      evt_ready_i = 1'b1;
      @(negedge clk_i);
      evt_ready_i = 1'b0;
    end
  endtask

  task automatic test_load();
    logic [21:0] e;
    drive_pkt(9'h005, 9'h003, 3'b100, 1, 700, 100);
    @(negedge clk_i);
    pkt_valid_i = 1'b0; pos_load_i = 1'b1; pos_x_i = 10'd700; pos_y_i = 9'd100;
    @(negedge clk_i);
    pos_load_i = 1'b0;
    e = pos_q.pop_front();
    checks++;
    if (x_pos_o !== 10'd639 || y_pos_o !== 9'd100 || btn_state_o !== e[2:0]) begin
      errors++; $display("FAIL load_pos: got (%0d,%0d,%b) want (639,100,%b)", x_pos_o, y_pos_o, btn_state_o, e[2:0]);
    end
    e = evt_q.pop_front();
    checks++;
    if (evt_valid_o !== 1'b1 || evt_data_o !== e) begin
      errors++; $display("FAIL load_evt: got vld=%b data=%h want vld=1 data=%h", evt_valid_o, evt_data_o, e);
    end
    evt_ready_i = 1'b1;
    @(negedge clk_i);
    evt_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [21:0] e;
    for (int i = 0; i < 16; i++) begin
      if (i >= 2) begin
        e = pos_q.pop_front();
        checks++;
        if (x_pos_o !== e[21:12] || y_pos_o !== e[11:3] || btn_state_o !== e[2:0]) begin
          errors++; $display("FAIL b2b_%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)", i - 2,
                             x_pos_o, y_pos_o, btn_state_o, e[21:12], e[11:3], e[2:0]);
        end
      end
      if (i < 14) begin
        cfg_swap_i  = 1'($urandom_range(0, 1));
        cfg_inv_x_i = 1'($urandom_range(0, 1));
        cfg_inv_y_i = 1'($urandom_range(0, 1));
        cfg_shift_i = 2'($urandom_range(0, 3));
        drive_pkt(9'($urandom), 9'($urandom), 3'($urandom), 0, 0, 0);
      end else pkt_valid_i = 1'b0;
      @(negedge clk_i);
    end
    cfg_swap_i = 1'b0; cfg_inv_x_i = 1'b0; cfg_inv_y_i = 1'b0; cfg_shift_i = 2'd0;
    checks++;
    if (evt_ovf_o !== exp_ovf) begin
      errors++; $display("FAIL b2b_ovf: got %b want %b", evt_ovf_o, exp_ovf);
    end
    while (evt_q.size() > 0) begin
      e = evt_q.pop_front();
      checks++;
      if (evt_valid_o !== 1'b1 || evt_data_o !== e) begin
        errors++; $display("FAIL b2b_evt: got vld=%b data=%h want vld=1 data=%h", evt_valid_o, evt_data_o, e);
      end
      evt_ready_i = 1'b1;
      @(negedge clk_i);
      evt_ready_i = 1'b0;
    end
    checks++;
    if (evt_valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got evt_valid=%b want 0", evt_valid_o);
    end
    clr_ovf_i = 1'b1;
    @(negedge clk_i);
    clr_ovf_i = 1'b0; exp_ovf = 1'b0;
  endtask

  task automatic test_full_pop_push();
    logic [21:0] e;
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) void'(pos_q.pop_front());
      if (i < 4) drive_pkt(9'h001, 9'h000, mbtn ^ 3'b001, 0, 0, 0);
      else pkt_valid_i = 1'b0;
      @(negedge clk_i);
    end
    e = evt_q.pop_front();
    checks++;
    if (evt_data_o !== e) begin
      errors++; $display("FAIL fpp_head: got %h want %h", evt_data_o, e);
    end
    drive_pkt(9'h001, 9'h000, mbtn ^ 3'b001, 0, 0, 0);
    @(negedge clk_i);
    pkt_valid_i = 1'b0; evt_ready_i = 1'b1;
    @(negedge clk_i);
    evt_ready_i = 1'b0;
    void'(pos_q.pop_front());
    checks++;
    if (evt_ovf_o !== 1'b0) begin
      errors++; $display("FAIL fpp_ovf: got %b want 0", evt_ovf_o);
    end
    while (evt_q.size() > 0) begin
      e = evt_q.pop_front();
      checks++;
      if (evt_valid_o !== 1'b1 || evt_data_o !== e) begin
        errors++; $display("FAIL fpp_evt: got vld=%b data=%h want vld=1 data=%h", evt_valid_o, evt_data_o, e);
      end
      evt_ready_i = 1'b1;
      @(negedge clk_i);
      evt_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] e;
    drive_pkt(9'h010, 9'h000, mbtn ^ 3'b100, 0, 0, 0);
    @(negedge clk_i);
    pkt_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (evt_valid_o !== 1'b1) begin
      errors++; $display("FAIL rst_pre_evt: got evt_valid=%b want 1", evt_valid_o);
    end
    drive_pkt(9'h005, 9'h000, 3'b000, 0, 0, 0);
    @(negedge clk_i);
    pkt_valid_i = 1'b0; rstn_i = 1'b0;
    #1;
    checks++;
    if (x_pos_o !== 10'd320 || y_pos_o !== 9'd240 || btn_state_o !== 3'b000 || btn_sticky_o !== 3'b000 ||
        evt_valid_o !== 1'b0 || evt_ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got x=%0d y=%0d btn=%b sticky=%b vld=%b ovf=%b want 320 240 000 000 0 0",
               x_pos_o, y_pos_o, btn_state_o, btn_sticky_o, evt_valid_o, evt_ovf_o);
    end
    model_reset();
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if (x_pos_o !== 10'd320 || y_pos_o !== 9'd240 || evt_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_discard: got (%0d,%0d) vld=%b want (320,240) vld=0", x_pos_o, y_pos_o, evt_valid_o);
    end
    drive_pkt(9'h005, 9'h1FD, 3'b000, 0, 0, 0);
    @(negedge clk_i);
    pkt_valid_i = 1'b0;
    @(negedge clk_i);
    e = pos_q.pop_front();
    checks++;
    if (x_pos_o !== e[21:12] || y_pos_o !== e[11:3]) begin
      errors++; $display("FAIL rst_after: got (%0d,%0d) want (%0d,%0d)", x_pos_o, y_pos_o, e[21:12], e[11:3]);
    end
  endtask

  initial begin
    rstn_i = 1'b0; pkt_valid_i = 1'b0; pkt_dx_i = '0; pkt_dy_i = '0; pkt_btn_i = '0;
    cfg_swap_i = 1'b0; cfg_inv_x_i = 1'b0; cfg_inv_y_i = 1'b0; cfg_shift_i = 2'd0;
    pos_load_i = 1'b0; pos_x_i = '0; pos_y_i = '0; ack_i = '0;
    evt_ready_i = 1'b0; clr_ovf_i = 1'b0;
    model_reset();
    test_reset();
    test_move();
    test_clamp();
    test_fifo_ovf();
    test_sticky();
    test_load();
    test_back_to_back();
    test_full_pop_push();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/mouse_pos_tracker.md
MOUSE_POS_TRACKER -- requirements
Module: mouse_pos_tracker

Interface
REQ-001 SHALL have parameter WIDTH, default 640: screen width in pixels; x range 0..WIDTH-1.
REQ-002 SHALL have parameter HEIGHT, default 480: screen height in pixels; y range 0..HEIGHT-1.
REQ-003 SHALL have parameter X_POS_W, default 10: x coordinate width, with 2**X_POS_W >= WIDTH.
REQ-004 SHALL have parameter Y_POS_W, default 9: y coordinate width, with 2**Y_POS_W >= HEIGHT.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: button-event FIFO depth, a power of 2 and at least 2.
REQ-006 Clock and reset: clk_i, clock; rstn_i, reset, asynchronous, active-low.
REQ-007 Ports (name  direction  width  meaning):
 clk_i  in  1  clock.
 rstn_i  in  1  asynchronous active-low reset.
 pkt_valid_i  in  1  one-cycle pulse: decoded PS/2 packet present.
 pkt_dx_i  in  9  two's-complement x delta.
 pkt_dy_i  in  9  two's-complement y delta, positive = up.
 pkt_btn_i  in  3  button levels {middle,right,left}.
 cfg_swap_i  in  1  swap dx/dy.
 cfg_inv_x_i  in  1  negate x delta.
 cfg_inv_y_i  in  1  negate y delta.
 cfg_shift_i  in  2  delta left-shift, gain 1/2/4/8.
 pos_load_i  in  1  load absolute position.
 pos_x_i  in  X_POS_W  load x value.
 pos_y_i  in  Y_POS_W  load y value.
 ack_i  in  3  per-bit sticky clear.
 x_pos_o  out  X_POS_W  current x.
 y_pos_o  out  Y_POS_W  current y.
 btn_state_o  out  3  last accepted button levels.
 btn_sticky_o  out  3  press-latched buttons.
 evt_valid_o  out  1  FIFO non-empty.
 evt_ready_i  in  1  consumer pop.
 evt_data_o  out  X_POS_W+Y_POS_W+3  FIFO head {x,y,btn}.
 evt_ovf_o  out  1  sticky FIFO overflow.
 clr_ovf_i  in  1  clears evt_ovf_o.

Function
REQ-008 Stage 1 SHALL register, when pkt_valid_i=1: the transformed deltas, pkt_btn_i, and a stage-2 valid bit.
REQ-009 Delta transform, in order:
 - sign-extend to 13 bits;
 - swap if cfg_swap_i;
 - negate x if cfg_inv_x_i, negate y if cfg_inv_y_i;
 - arithmetic left-shift by cfg_shift_i.
REQ-010 Stage 2 position update SHALL be x_new = x + dx and y_new = y - dy (screen y grows downward).
REQ-011 Stage 2 SHALL compute x_new and y_new in signed arithmetic wide enough to avoid overflow, then saturate into 0..WIDTH-1 and 0..HEIGHT-1.
REQ-012 x_pos_o and y_pos_o SHALL reflect a packet exactly 2 cycles after its pkt_valid_i pulse; back-to-back pulses SHALL all be processed, with throughput 1 packet/cycle.
REQ-013 pos_load_i SHALL load saturated pos_x_i/pos_y_i on the next edge and take priority over a stage-2 packet; that packet's movement is discarded but its button processing still occurs.
REQ-014 On a stage-2 packet, btn_state_o SHALL take the packet's buttons, and btn_sticky_o bits SHALL be set where the packet's button bit is 1.
REQ-015 ack_i[n]=1 SHALL clear btn_sticky_o[n]; a simultaneous set of the same bit wins, so the bit stays 1.
REQ-016 A stage-2 packet whose buttons differ from btn_state_o SHALL push {x_new_saturated, y_new_saturated, btn} into the FIFO; position-only packets SHALL NOT push.
REQ-017 Under pos_load_i, the pushed x/y for such a packet SHALL be the loaded values.
REQ-018 FIFO order SHALL be first-in first-out, with evt_data_o = head and evt_valid_o = not empty.
REQ-019 A pop SHALL occur when evt_valid_o && evt_ready_i.
REQ-020 A push when full SHALL be accepted only if a pop occurs in the same cycle; otherwise it is dropped and evt_ovf_o is set.
REQ-021 evt_ready_i when empty SHALL have no effect.
REQ-022 clr_ovf_i SHALL clear evt_ovf_o; a simultaneous overflow wins, so evt_ovf_o stays 1.
REQ-023 Configuration inputs SHALL be sampled only at stage 1; changing them mid-flight SHALL NOT affect a packet already in stage 2.

Reset
REQ-024 Asynchronous assertion of rstn_i SHALL force:
 - x_pos_o=WIDTH/2, y_pos_o=HEIGHT/2;
 - btn_state_o=0, btn_sticky_o=0;
 - FIFO empty, evt_valid_o=0, evt_ovf_o=0;
 - stage-1/stage-2 valid bits cleared.
REQ-025 Reset mid-operation SHALL discard in-flight packets and FIFO contents; the first packet after deassertion SHALL follow REQ-012 timing.

Verification (defaults; cfg all 0 unless stated)
REQ-026 Reset release -> x=320, y=240, btn_sticky=0, evt_valid=0, evt_ovf=0.
REQ-027 dx=9'h005, dy=9'h1FD (-3) -> 2 cycles later x=325, y=243; no FIFO push.
REQ-028 Clamping and transform:
 - cfg_shift=3, dx=9'h0FF twice -> x=639;
 - then cfg_inv_x=1, dx=9'h0FF, 3 packets -> x=0, no wrap;
 - cfg_swap=1, dx=0, dy=9'h004 -> x+4.
REQ-029 FIFO overflow: evt_ready=0, 5 packets alternating btn 3'b001/3'b000 -> 4 entries and evt_ovf=1; pops return entries in order with btn 001,000,001,000.
REQ-030 Sticky: packet with btn=3'b010 -> btn_sticky=010; ack_i=010 in the same cycle as a btn=010 packet's stage 2 -> bit stays 1; ack alone -> 000.
REQ-031 Load and reset: pos_load_i with pos=(700,100) in the same cycle as a movement packet in stage 2 -> x=639, y=100; rstn_i pulse mid-stream -> REQ-024 values.
